// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-FF synchroniser, mid-bit sampling, one-byte
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 27
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       DATA_VALID,
    input  logic       DATA_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);

    localparam int CW = (CLKS_PER_BIT > 4) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          deliver, ferr;
    logic          accept;

    assign accept = DATA_VALID && DATA_READY;

    // Idle-high synchroniser so reset never looks like a start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RXD;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        deliver = 1'b0;
        ferr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end
            ST_START: begin
                if (cnt != HALF) begin
                    cnt_n = cnt + 1'b1;
                end else if (!rx_s) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt != LAST) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    shift_n[idx] = rx_s;
                    cnt_n        = '0;
                    if (idx == 3'd7) state_n = ST_STOP;
                    else             idx_n   = idx + 1'b1;
                end
            end
            ST_STOP: begin
                // Leaving mid-stop-bit lets the next start edge be caught with no gap.
                if (cnt != LAST) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n   = '0;
                    deliver = rx_s;
                    ferr    = !rx_s;
                    state_n = rx_s ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            FRAME_ERR <= ferr;
            OVERRUN   <= 1'b0;
            if (deliver) begin
                // A byte accepted on this same edge frees the register for the new one.
                if (!DATA_VALID || DATA_READY) begin
                    DATA       <= shift;
                    DATA_VALID <= 1'b1;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end else if (accept) begin
                DATA_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed plan steps plus random frames, compared
// every cycle against a frame-level model of the holding register.
`timescale 1ns/100ps
module tb_uart_rx_byte;

    localparam int CPB  = 27;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic       DATA_READY = 1'b0;
    logic [7:0] DATA;
    logic       DATA_VALID, FRAME_ERR, OVERRUN;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD),
        .DATA(DATA), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
        .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
    );

    always #18.5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    ev_t        ev_q[$];
    ev_t        e_cur;
    int         cyc = 0;
    logic       rdy_q = 1'b0;
    logic       rst_q = 1'b1;
    bit         rnd_rdy = 1'b0;
    logic       mv = 1'b0;
    logic [7:0] md = 8'h00;
    logic       fe = 1'b0;
    logic       ov = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rdy_q <= DATA_READY;
        rst_q <= RST;
    end

    // Model: each frame's stop sample is known from its start time; between
    // those, the register only changes through the valid/ready handshake.
    always @(negedge CLK) begin
        if (RST || rst_q) begin
            mv = 1'b0; md = 8'h00; fe = 1'b0; ov = 1'b0;
            ev_q.delete();
        end else begin
            fe = 1'b0;
            ov = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                e_cur = ev_q.pop_front();
                if (!e_cur.ok) begin
                    fe = 1'b1;
                    if (mv && rdy_q) mv = 1'b0;
                end else if (!mv || rdy_q) begin
                    md = e_cur.b;
                    mv = 1'b1;
                end else begin
                    ov = 1'b1;
                end
            end else if (mv && rdy_q) begin
                mv = 1'b0;
            end
        end
        chk("data",       {24'd0, DATA}, {24'd0, md});
        chk("data_valid", 32'(DATA_VALID), 32'(mv));
        chk("frame_err",  32'(FRAME_ERR),  32'(fe));
        chk("overrun",    32'(OVERRUN),    32'(ov));
    end

    task automatic wait_cyc(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (rnd_rdy) DATA_READY = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(logic [7:0] b, bit stop_ok, int hold);
        ev_q.push_back('{cyc: cyc + 1 + LAT, b: b, ok: stop_ok});
        RXD = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            wait_cyc(CPB);
        end
        RXD = stop_ok;
        wait_cyc(CPB);
        if (!stop_ok) wait_cyc(hold);
        RXD = 1'b1;
    endtask

    initial begin
        // Reset held for ~1 us with a noisy line.
        repeat (27) begin
            @(posedge CLK);
            #1;
            RXD = 1'($urandom);
        end
        RXD = 1'b1;
        chk("rst_data", {24'd0, DATA}, 32'h00);
        chk("rst_valid", 32'(DATA_VALID), 32'd0);
        RST = 1'b0;
        wait_cyc(50);
        chk("idle_no_byte", 32'(DATA_VALID), 32'd0);

        DATA_READY = 1'b1;
        send_frame(8'h55, 1'b1, 0);
        wait_cyc(20);
        chk("b55_data", {24'd0, DATA}, 32'h55);
        chk("b55_consumed", 32'(DATA_VALID), 32'd0);

        DATA_READY = 1'b0;
        wait_cyc(385);
        send_frame(8'hA3, 1'b1, 0);
        wait_cyc(60);
        chk("a3_held", 32'(DATA_VALID), 32'd1);
        chk("a3_data", {24'd0, DATA}, 32'hA3);
        DATA_READY = 1'b1;
        wait_cyc(1);
        DATA_READY = 1'b0;
        wait_cyc(5);
        chk("a3_accepted", 32'(DATA_VALID), 32'd0);

        wait_cyc(30);
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        wait_cyc(30);
        chk("ovr_keeps_first", {24'd0, DATA}, 32'h11);
        chk("ovr_valid", 32'(DATA_VALID), 32'd1);
        DATA_READY = 1'b1;
        wait_cyc(1);

        wait_cyc(30);
        send_frame(8'h5A, 1'b0, 81);
        wait_cyc(30);
        chk("ferr_no_byte", 32'(DATA_VALID), 32'd0);
        send_frame(8'h3C, 1'b1, 0);
        wait_cyc(20);
        chk("after_break", {24'd0, DATA}, 32'h3C);

        wait_cyc(30);
        RXD = 1'b0;
        wait_cyc(5);
        RXD = 1'b1;
        wait_cyc(60);
        chk("glitch_no_byte", 32'(DATA_VALID), 32'd0);

        // Partial frame interrupted by reset in the middle of data bit 4.
        RXD = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            RXD = i[0];
            wait_cyc(CPB);
        end
        RXD = 1'b0;
        wait_cyc(HALF);
        RST = 1'b1;
        wait_cyc(3);
        chk("midrst_data", {24'd0, DATA}, 32'h00);
        chk("midrst_valid", 32'(DATA_VALID), 32'd0);
        RXD = 1'b1;
        wait_cyc(2);
        RST = 1'b0;
        wait_cyc(30);
        send_frame(8'hC3, 1'b1, 0);
        wait_cyc(20);
        chk("after_rst_c3", {24'd0, DATA}, 32'hC3);

        rnd_rdy = 1'b1;
        for (int f = 0; f < 24; f++) begin
            logic [7:0] b;
            bit         ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_frame(b, ok, ok ? 0 : int'($urandom_range(0, 60)));
            wait_cyc(ok ? int'($urandom_range(0, 40)) : int'($urandom_range(5, 40)));
        end
        rnd_rdy = 1'b0;
        DATA_READY = 1'b0;
        wait_cyc(300);
        chk("events_drained", ev_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
